msf_frame_encoder: RTL and testbench
====================================

Name: msf_frame_encoder

Overview:
- Generates a complete MSF 60 kHz time-code modulation envelope (carrier-off = 1) from BCD time/date inputs.
- It is the transmit-side counterpart of the receive chain (bit sampler, decoder, time/date decoder). It drives a carrier gate or loops back into the receive chain for self-test.
- Internal prescaler → 100 ms slot counter → second counter. Inputs are latched once per minute into a shadow frame.

Parameters:
- DIV, 3276, clock cycles per 100 ms slot; legal range 2 .. 65535.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- en_i  in  1  run enable; low freezes all counters and forces data_o=0
- year_h_i  in  4  BCD year tens
- year_l_i  in  4  BCD year units
- month_h_i  in  1  BCD month tens
- month_l_i  in  4  BCD month units
- day_h_i  in  2  BCD day tens
- day_l_i  in  4  BCD day units
- dow_i  in  3  day of week 0-6
- hour_h_i  in  2  BCD hour tens
- hour_l_i  in  4  BCD hour units
- minute_h_i  in  3  BCD minute tens
- minute_l_i  in  4  BCD minute units
- data_o  out  1  envelope, 1 = carrier off
- second_o  out  6  current second 0-59
- frame_o  out  1  one-cycle pulse when inputs are latched (start of second 00)

Behaviour:
- Reset: prescaler, slot (0-9) and second (0-59) counters = 0; shadow frame = 0; data_o=0, second_o=0, frame_o=0.
- Counting:
  - While en_i=1, the prescaler counts 0..DIV-1.
  - On wrap, slot increments; slot 9→0 increments second; second 59→0 wraps. No leap seconds.
  - While en_i=0, all counters hold.
- Latch:
  - When en_i=1 and prescaler=0, slot=0, second=0, the shadow frame captures all inputs in that cycle.
  - frame_o=1 for that single cycle, including the first enabled cycle after reset.
  - The caller supplies the time of the minute that follows the frame.
- Bit map (A bits, MSB first):
  - 01-16 = 0
  - 17-24 = year_h:year_l
  - 25-29 = month_h:month_l
  - 30-35 = day_h:day_l
  - 36-38 = dow
  - 39-44 = hour_h:hour_l
  - 45-51 = minute_h:minute_l
  - 52-59 = 0111_1110
- B bits: 0 except:
  - 54 = odd parity over 17A-24A
  - 55 = odd parity over 25A-35A
  - 56 = odd parity over 36A-38A
  - 57 = odd parity over 39A-51A
  - Parity bit is chosen so that covered bits plus the parity bit hold an odd count of ones.
  - 53B and 58B are set per the optional feature.
- Envelope per second (slot s, 100 ms each):
  - second 00: off for s=0-4, on for s=5-9.
  - A=0,B=0: off s=0.
  - A=1,B=0: off s=0-1.
  - A=1,B=1: off s=0-2.
  - A=0,B=1: off s=0 and s=2 only.
  - All other slots on.
- data_o and second_o are registered from the current counter/shadow state: one-cycle latency, changing the cycle after the counter change.
- en_i falling mid-second: data_o=0 the next cycle. On re-enable, resume at the held position.
- rst_i takes priority over en_i and applies mid-frame. The next enabled cycle restarts at second 00 with a fresh latch.
- Inputs are not range-checked; invalid BCD is encoded verbatim.

Optional Feature:
- Macro MSF_FRAME_ENCODER_DST_EN.
- Defined: adds inputs dst_warn_i (1b) and dst_i (1b). They are latched with the frame and drive 53B and 58B.
- Undefined: ports absent; 53B=58B=0.

Test Plan:
- DIV=2, reset, en_i=1:
  - frame_o pulses exactly 1 cycle after reset release.
  - data_o=1 for cycles 2-11, 0 for cycles 12-21.
  - Then second_o=1.
- DIV=2, load year=24, month=02, day=29, dow=4, hour=23, minute=59:
  - second 19: off 4 cycles (A=1).
  - second 17: off 2 cycles.
  - 54B=1 and 55B=1, so seconds 54 and 55 are off 6 cycles.
  - 56B=0 and 57B=0, so seconds 56 and 57 are off 4 cycles.
- Same load: second 52 off 2 cycles, second 59 off 2 cycles; after second 59, frame_o pulses and second 00 repeats 10 off / 10 on.
- Change inputs mid-minute (second 30): no change in emitted bits until the next frame_o.
- en_i low for 7 cycles during second 00 slot 2: data_o=0 while low; second_o holds; 500 ms off-time resumes for the remaining slots.
- rst_i at second 40 slot 3: data_o=0, second_o=0 next cycle; restart at second 00 with new latch.
- Loopback into the receive chain with DIV matching the system: decoded time equals the loaded time after one full frame.

Source files
------------

// File: rtl/msf_frame_encoder.sv
// MSF 60 kHz time-code envelope generator (data_o = 1 means carrier off).
// A prescaler of DIV cycles makes 100 ms slots. Ten slots make one second,
// and sixty seconds make one minute. The BCD time/date inputs are copied into
// a shadow frame at the start of second 00 and then encoded as the A/B bits.
// Optional feature macro: MSF_FRAME_ENCODER_DST_EN adds dst_warn_i and dst_i,
// which drive bits 53B and 58B.
module msf_frame_encoder #(
    parameter int unsigned DIV = 3276
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [3:0] year_h_i,
    input  logic [3:0] year_l_i,
    input  logic       month_h_i,
    input  logic [3:0] month_l_i,
    input  logic [1:0] day_h_i,
    input  logic [3:0] day_l_i,
    input  logic [2:0] dow_i,
    input  logic [1:0] hour_h_i,
    input  logic [3:0] hour_l_i,
    input  logic [2:0] minute_h_i,
    input  logic [3:0] minute_l_i,
`ifdef MSF_FRAME_ENCODER_DST_EN
    input  logic       dst_warn_i,
    input  logic       dst_i,
`endif
    output logic       data_o,
    output logic [5:0] second_o,
    output logic       frame_o
);

    localparam logic [15:0] PRE_MAX = 16'(DIV - 1);

    // The 35 time/date bits are stored MSB first, in on-air order (17A .. 51A).
    typedef struct packed {
        logic [34:0] fld;
        logic        dst_warn;
        logic        dst;
    } frame_t;

    logic [15:0] pre;
    logic [3:0]  slot;
    logic [5:0]  sec;
    frame_t      shadow;
    frame_t      live;
    logic        latch;
    logic [63:0] a_bits;
    logic [63:0] b_bits;
    logic        a_cur;
    logic        b_cur;
    logic        env;

    // Collect the live inputs into the shape the shadow frame uses.
    always_comb begin
        live.fld = {year_h_i, year_l_i, month_h_i, month_l_i, day_h_i, day_l_i,
                    dow_i, hour_h_i, hour_l_i, minute_h_i, minute_l_i};
`ifdef MSF_FRAME_ENCODER_DST_EN
        live.dst_warn = dst_warn_i;
        live.dst      = dst_i;
`else
        live.dst_warn = 1'b0;
        live.dst      = 1'b0;
`endif
    end

    // Capture happens on the very first cycle of second 00.
    assign latch = en_i && (pre == 16'd0) && (slot == 4'd0) && (sec == 6'd0);

    // Prescaler, slot and second counters; all hold while en_i is low.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pre  <= '0;
            slot <= '0;
            sec  <= '0;
        end else if (en_i) begin
            if (pre == PRE_MAX) begin
                pre <= '0;
                if (slot == 4'd9) begin
                    slot <= '0;
                    sec  <= (sec == 6'd59) ? 6'd0 : sec + 6'd1;
                end else begin
                    slot <= slot + 4'd1;
                end
            end else begin
                pre <= pre + 16'd1;
            end
        end
    end

    // The shadow frame keeps mid-minute input changes off the air until
    // the next minute starts.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shadow <= '0;
        end else if (latch) begin
            shadow <= live;
        end
    end

    // Expand the shadow frame into per-second A and B bit vectors, indexed by second.
    always_comb begin
        a_bits = '0;
        b_bits = '0;
        for (int i = 0; i < 35; i++) begin
            a_bits[17 + i] = shadow.fld[34 - i];
        end
        a_bits[58:53] = 6'b111111;          // 52..59 = 0111_1110
        b_bits[53] = shadow.dst_warn;
        b_bits[54] = ~^shadow.fld[34:27];   // year
        b_bits[55] = ~^shadow.fld[26:16];   // month + day
        b_bits[56] = ~^shadow.fld[15:13];   // day of week
        b_bits[57] = ~^shadow.fld[12:0];    // hour + minute
        b_bits[58] = shadow.dst;
    end

    // Work out which 100 ms slots of the current second are carrier-off.
    always_comb begin
        a_cur = a_bits[sec];
        b_cur = b_bits[sec];
        env   = 1'b0;
        if (sec == 6'd0) begin
            env = (slot < 4'd5);
        end else begin
            case (slot)
                4'd0:    env = 1'b1;
                4'd1:    env = a_cur;
                4'd2:    env = b_cur;
                default: env = 1'b0;
            endcase
        end
    end

    // Register the outputs one cycle after the counter state they describe.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_o   <= 1'b0;
            second_o <= '0;
            frame_o  <= 1'b0;
        end else begin
            data_o   <= en_i & env;
            second_o <= sec;
            frame_o  <= latch;
        end
    end

endmodule

// File: tb/tb_msf_frame_encoder.sv
// Self-checking bench for msf_frame_encoder with DIV=2. A reference model
// tracks the position within the minute as one integer and derives the
// envelope from field tables and parity counts.
module tb_msf_frame_encoder;

    localparam int DIV  = 2;
    localparam int SECT = 10 * DIV;     // cycles per second
    localparam int MINT = 60 * SECT;    // cycles per minute

    logic       clk = 1'b0;
    logic       rst_i, en_i;
    logic [3:0] year_h_i, year_l_i, month_l_i, day_l_i, hour_l_i, minute_l_i;
    logic       month_h_i;
    logic [1:0] day_h_i, hour_h_i;
    logic [2:0] dow_i, minute_h_i;
    logic       dst_warn_i, dst_i;
    logic       data_o, frame_o;
    logic [5:0] second_o;

    always #5 clk = ~clk;

    msf_frame_encoder #(.DIV(DIV)) dut (
        .clk_i(clk), .rst_i(rst_i), .en_i(en_i),
        .year_h_i(year_h_i), .year_l_i(year_l_i),
        .month_h_i(month_h_i), .month_l_i(month_l_i),
        .day_h_i(day_h_i), .day_l_i(day_l_i), .dow_i(dow_i),
        .hour_h_i(hour_h_i), .hour_l_i(hour_l_i),
        .minute_h_i(minute_h_i), .minute_l_i(minute_l_i),
`ifdef MSF_FRAME_ENCODER_DST_EN
        .dst_warn_i(dst_warn_i), .dst_i(dst_i),
`endif
        .data_o(data_o), .second_o(second_o), .frame_o(frame_o)
    );

    int errors = 0;
    int checks = 0;

    // Model state: position within the minute plus the latched field values.
    int m_pos = 0;
    int m_val[11];
    int m_dw = 0, m_dst = 0;
    int f_start[11] = '{17, 21, 25, 26, 30, 32, 36, 39, 41, 45, 48};
    int f_width[11] = '{4, 4, 1, 4, 2, 4, 3, 2, 4, 3, 4};

    bit rec = 0;
    int rec_idx = 0;
    int offcnt[60];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int abit(input int n);
        if (n >= 53 && n <= 58) return 1;
        for (int f = 0; f < 11; f++)
            if (n >= f_start[f] && n < f_start[f] + f_width[f])
                return (m_val[f] >> (f_width[f] - 1 - (n - f_start[f]))) & 1;
        return 0;
    endfunction

    function automatic int par(input int lo, input int hi);
        int c = 0;
        for (int n = lo; n <= hi; n++) c += abit(n);
        return (c % 2 == 0) ? 1 : 0;
    endfunction

    function automatic int bbit(input int n);
        case (n)
            53: return m_dw;
            54: return par(17, 24);
            55: return par(25, 35);
            56: return par(36, 38);
            57: return par(39, 51);
            58: return m_dst;
            default: return 0;
        endcase
    endfunction

    function automatic int env(input int s, input int sl);
        int a, b;
        if (s == 0) return (sl < 5) ? 1 : 0;
        a = abit(s);
        b = bbit(s);
        if (a == 1 && b == 1) return (sl < 3) ? 1 : 0;
        if (a == 1) return (sl < 2) ? 1 : 0;
        if (b == 1) return (sl == 0 || sl == 2) ? 1 : 0;
        return (sl == 0) ? 1 : 0;
    endfunction

    task automatic model_latch();
        m_val[0] = year_h_i;   m_val[1] = year_l_i;
        m_val[2] = month_h_i;  m_val[3] = month_l_i;
        m_val[4] = day_h_i;    m_val[5] = day_l_i;
        m_val[6] = dow_i;
        m_val[7] = hour_h_i;   m_val[8] = hour_l_i;
        m_val[9] = minute_h_i; m_val[10] = minute_l_i;
`ifdef MSF_FRAME_ENCODER_DST_EN
        m_dw = dst_warn_i; m_dst = dst_i;
`else
        m_dw = 0; m_dst = 0;
`endif
    endtask

    task automatic rand_inputs();
        year_h_i   = 4'($urandom_range(0, 15));
        year_l_i   = 4'($urandom_range(0, 15));
        month_h_i  = 1'($urandom_range(0, 1));
        month_l_i  = 4'($urandom_range(0, 15));
        day_h_i    = 2'($urandom_range(0, 3));
        day_l_i    = 4'($urandom_range(0, 15));
        dow_i      = 3'($urandom_range(0, 7));
        hour_h_i   = 2'($urandom_range(0, 3));
        hour_l_i   = 4'($urandom_range(0, 15));
        minute_h_i = 3'($urandom_range(0, 7));
        minute_l_i = 4'($urandom_range(0, 15));
        dst_warn_i = 1'($urandom_range(0, 1));
        dst_i      = 1'($urandom_range(0, 1));
    endtask

    // One clock: predict outputs from the pre-edge state, step, then compare.
    task automatic tick();
        int ed, es, ef;
        if (rst_i) begin
            ed = 0; es = 0; ef = 0;
            m_pos = 0;
            foreach (m_val[i]) m_val[i] = 0;
            m_dw = 0; m_dst = 0;
        end else if (en_i) begin
            es = m_pos / SECT;
            ed = env(es, (m_pos / DIV) % 10);
            ef = (m_pos == 0) ? 1 : 0;
            if (ef == 1) model_latch();
            m_pos = (m_pos + 1) % MINT;
        end else begin
            ed = 0; es = m_pos / SECT; ef = 0;
        end
        @(posedge clk);
        #1;
        check("data_o", 32'(data_o), 32'(ed));
        check("second_o", 32'(second_o), 32'(es));
        check("frame_o", 32'(frame_o), 32'(ef));
        if (rec) begin
            if (rec_idx < MINT) offcnt[rec_idx / SECT] += int'(data_o);
            rec_idx++;
        end
    endtask

    int exp_sec[10] = '{0, 17, 19, 52, 53, 54, 55, 56, 57, 59};
    int exp_off[10] = '{10, 2, 4, 2, 4, 6, 6, 4, 4, 2};

    initial begin
        rst_i = 1'b1; en_i = 1'b0;
        // Directed load: 24-02-29, dow 4, 23:59
        year_h_i = 4'd2; year_l_i = 4'd4; month_h_i = 1'b0; month_l_i = 4'd2;
        day_h_i = 2'd2; day_l_i = 4'd9; dow_i = 3'd4;
        hour_h_i = 2'd2; hour_l_i = 4'd3; minute_h_i = 3'd5; minute_l_i = 4'd9;
        dst_warn_i = 1'b0; dst_i = 1'b0;
        foreach (m_val[i]) m_val[i] = 0;
        repeat (3) tick();

        // First minute: record carrier-off cycles per second.
        rst_i = 1'b0; en_i = 1'b1;
        foreach (offcnt[i]) offcnt[i] = 0;
        rec = 1; rec_idx = 0;
        tick();
        check("first_frame", 32'(frame_o), 32'd1);
        while (rec_idx < MINT) begin
            if (rec_idx == 30 * SECT) rand_inputs();   // must not affect this minute
            tick();
        end
        rec = 0;
        for (int i = 0; i < 10; i++)
            check($sformatf("off_sec%0d", exp_sec[i]), 32'(offcnt[exp_sec[i]]), 32'(exp_off[i]));

        // Second minute: pause for 7 cycles at second 00, slot 2.
        repeat (2 * DIV) tick();
        en_i = 1'b0;
        repeat (7) tick();
        en_i = 1'b1;
        for (int g = 0; g < MINT && m_pos != 40 * SECT + 3 * DIV; g++) tick();

        // Reset at second 40, slot 3, then restart with a fresh latch.
        rand_inputs();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        tick();
        check("restart_frame", 32'(frame_o), 32'd1);
        repeat (MINT + 40) tick();

        // Random enable gaps and input churn.
        for (int k = 0; k < 1500; k++) begin
            en_i = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 99) == 0) rand_inputs();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
